// File: rtl/l2_pmem_responder.sv
// l2_pmem_responder: line-granular main-memory model behind the L2 pmem_* port.
// Each request is held for LATENCY cycles, then completed with a one-cycle o_pmem_resp.
module l2_pmem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int IDX_BITS   = 8,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_pmem_read,
    input  logic                  i_pmem_write,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    input  logic [LINE_WIDTH-1:0] i_pmem_wdata,
    output logic [LINE_WIDTH-1:0] o_pmem_rdata,
    output logic                  o_pmem_resp
);
    localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);
    localparam int CNT_W    = $clog2(LATENCY + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_op_wr;
    logic [IDX_BITS-1:0]   r_idx;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic [LINE_WIDTH-1:0] r_rdata;
    logic [LINE_WIDTH-1:0] r_mem [2**IDX_BITS];

    logic                  w_req;
    logic                  w_op_line;
    logic                  w_rd_load;
    logic [IDX_BITS-1:0]   w_idx;
    logic [IDX_BITS-1:0]   w_rd_idx;
    logic                  w_unused;

    assign w_idx     = i_pmem_address[OFF_BITS +: IDX_BITS];
    assign w_unused  = ^{i_pmem_address[ADDR_WIDTH-1:OFF_BITS+IDX_BITS], i_pmem_address[OFF_BITS-1:0]};
    assign w_req     = i_pmem_read | i_pmem_write;
    assign w_op_line = r_op_wr ? i_pmem_write : i_pmem_read;
    assign w_rd_idx  = (r_state == S_IDLE) ? w_idx : r_idx;
    // Read data is fetched on the edge entering RESP so it is valid during the pulse.
    assign w_rd_load = (r_state == S_IDLE && LATENCY == 1 && w_req && !i_pmem_write) ||
                       (r_state == S_BUSY && w_op_line && r_cnt == CNT_W'(1) && !r_op_wr);
    assign o_pmem_resp  = (r_state == S_RESP);
    assign o_pmem_rdata = r_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op_wr <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_rd_load)
                r_rdata <= r_mem[w_rd_idx];
            case (r_state)
                S_IDLE: if (w_req) begin
                    r_op_wr <= i_pmem_write;
                    r_idx   <= w_idx;
                    r_wdata <= i_pmem_wdata;
                    r_cnt   <= CNT_W'(LATENCY - 1);
                    r_state <= (LATENCY == 1) ? S_RESP : S_BUSY;
                end
                S_BUSY: begin
                    if (!w_op_line)
                        r_state <= S_IDLE;
                    else if (r_cnt == CNT_W'(1))
                        r_state <= S_RESP;
                    else
                        r_cnt <= r_cnt - CNT_W'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Storage is not reset; a reset landing on RESP must not commit the write.
    always_ff @(posedge clk) begin
        if (rst_n && r_state == S_RESP && r_op_wr)
            r_mem[r_idx] <= r_wdata;
    end
endmodule

// File: tb/tb_l2_pmem_responder.sv
// tb_l2_pmem_responder: directed vectors for the LATENCY=4 build plus a LATENCY=1 instance.
module tb_l2_pmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         rd, wr, rd1, wr1;
    logic [31:0]  addr, addr1;
    logic [255:0] wdata, wdata1, rdata, rdata1;
    logic         resp, resp1;

    int checks = 0;
    int errors = 0;

    l2_pmem_responder #(.LATENCY(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_pmem_read(rd), .i_pmem_write(wr),
        .i_pmem_address(addr), .i_pmem_wdata(wdata),
        .o_pmem_rdata(rdata), .o_pmem_resp(resp)
    );

    l2_pmem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_pmem_read(rd1), .i_pmem_write(wr1),
        .i_pmem_address(addr1), .i_pmem_wdata(wdata1),
        .o_pmem_rdata(rdata1), .o_pmem_resp(resp1)
    );

    typedef struct {
        logic         wr;
        logic         rd;
        logic [31:0]  addr;
        logic [255:0] data;
        logic [255:0] exp;
    } vec_t;

    vec_t v[10];

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic wait_resp(output int n);
        n = 99;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (resp === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_resp1(output int n);
        n = 99;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (resp1 === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic watch_no_resp(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (resp !== 1'b0) seen++;
        end
        chk(name, 256'(seen), 256'(0));
    endtask

    logic [255:0] pa5, p5a, p1234, pc3, p11, pee, d;
    logic [7:0]   b;
    int n;

    initial begin
        pa5   = {32{8'hA5}};
        p5a   = {32{8'h5A}};
        p1234 = {16{16'h1234}};
        pc3   = {32{8'hC3}};
        p11   = {32{8'h11}};
        pee   = {32{8'hEE}};
        v[0] = '{1'b1, 1'b0, 32'h0000_0040, pa5,   256'd0};
        v[1] = '{1'b0, 1'b1, 32'h0000_0040, 256'd0, pa5};
        v[2] = '{1'b1, 1'b0, 32'h0000_0060, p5a,   pa5};
        v[3] = '{1'b0, 1'b1, 32'h0000_0060, 256'd0, p5a};
        v[4] = '{1'b1, 1'b0, 32'h0000_2020, p1234, p5a};
        v[5] = '{1'b0, 1'b1, 32'hFFFF_2020, 256'd0, p1234};
        v[6] = '{1'b1, 1'b1, 32'h0000_0100, pc3,   p1234};
        v[7] = '{1'b0, 1'b1, 32'h0000_0100, 256'd0, pc3};
        v[8] = '{1'b1, 1'b0, 32'h0000_0080, p11,   pc3};
        v[9] = '{1'b0, 1'b1, 32'h0000_0040, 256'd0, pa5};

        rst_n = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (2) @(negedge clk);
        chk("reset_resp", 256'(resp), 256'(0));
        chk("reset_rdata", rdata, 256'd0);
        chk("reset_resp1", 256'(resp1), 256'(0));
        chk("reset_rdata1", rdata1, 256'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            wr = v[i].wr; rd = v[i].rd; addr = v[i].addr; wdata = v[i].data;
            wait_resp(n);
            chk($sformatf("vec%0d_latency", i), 256'(n), 256'(4));
            chk($sformatf("vec%0d_rdata", i), rdata, v[i].exp);
            wr = 1'b0; rd = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_pulse_width", i), 256'(resp), 256'(0));
        end

        // write held through RESP, then read raised right after
        wr = 1'b1; addr = 32'h0000_0060; wdata = p5a;
        wait_resp(n);
        chk("b2b_first_latency", 256'(n), 256'(4));
        wr = 1'b0; rd = 1'b1; addr = 32'h0000_0040;
        wait_resp(n);
        chk("b2b_pulse_spacing", 256'(n), 256'(5));
        chk("b2b_read_rdata", rdata, pa5);
        // read kept high past RESP: no second pulse immediately
        @(negedge clk);
        chk("held_read_no_repulse", 256'(resp), 256'(0));
        rd = 1'b0;
        watch_no_resp("held_read_drop_quiet", 6);

        // abort a write in BUSY
        wr = 1'b1; addr = 32'h0000_0080; wdata = pee;
        repeat (2) @(negedge clk);
        wr = 1'b0;
        watch_no_resp("abort_no_resp", 8);
        rd = 1'b1; addr = 32'h0000_0080;
        wait_resp(n);
        chk("abort_read_latency", 256'(n), 256'(4));
        chk("abort_read_rdata", rdata, p11);
        rd = 1'b0;
        @(negedge clk);

        // reset during BUSY
        wr = 1'b1; addr = 32'h0000_0080; wdata = pee;
        repeat (2) @(negedge clk);
        rst_n = 1'b0; wr = 1'b0;
        @(negedge clk);
        chk("rst_busy_resp", 256'(resp), 256'(0));
        chk("rst_busy_rdata", rdata, 256'd0);
        rst_n = 1'b1;
        watch_no_resp("rst_busy_quiet", 6);
        rd = 1'b1; addr = 32'h0000_0080;
        wait_resp(n);
        chk("rst_read_rdata", rdata, p11);
        rd = 1'b0;
        @(negedge clk);

        // LATENCY=1 instance: alternating write/read every RESP
        addr1 = 32'h0000_0020;
        for (int k = 0; k < 4; k++) begin
            b = 8'h30 + 8'(k / 2);
            d = {32{b}};
            wr1 = (k % 2 == 0); rd1 = (k % 2 == 1); wdata1 = d;
            wait_resp1(n);
            chk($sformatf("l1_op%0d_spacing", k), 256'(n), 256'((k == 0) ? 1 : 2));
            if (k % 2 == 1) chk($sformatf("l1_op%0d_rdata", k), rdata1, d);
        end
        wr1 = 1'b0; rd1 = 1'b0;
        @(negedge clk);
        chk("l1_pulse_width", 256'(resp1), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/l2_pmem_responder.md
# l2_pmem_responder

Physical-memory responder for the L2 cache's `pmem_*` interface. It accepts one line-sized read or write request at a time, holds it for a parameterised access latency, and then completes it against an internal line-granular storage array. It pulses `pmem_resp` for exactly one cycle to finish each request. It sits below the L2 cache control/datapath and serves as the synthesizable main-memory model for system simulation and FPGA builds.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of `pmem_address`.
- `LINE_WIDTH`, 256: bits per line; offset bits = log2(LINE_WIDTH/8) = 5.
- `IDX_BITS`, 8: line index bits; the array holds 2^IDX_BITS lines.
- `LATENCY`, 4: cycles from request acceptance to `pmem_resp`; legal range 1–255.

Ports:
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset. Synchronous, active-low.
- `pmem_read`, in, 1: read request level. Held until `pmem_resp`.
- `pmem_write`, in, 1: write request level. Held until `pmem_resp`.
- `pmem_address`, in, ADDR_WIDTH: line address. Offset bits are ignored.
- `pmem_wdata`, in, LINE_WIDTH: write line data.
- `pmem_rdata`, out, LINE_WIDTH: read line data. Valid in the `pmem_resp` cycle of a read.
- `pmem_resp`, out, 1: completion pulse, one cycle per request.

## Operation
- State machine: IDLE, BUSY, RESP.
- IDLE:
  - If `pmem_read | pmem_write`, accept the request.
  - Capture the op (write has priority if both are high), the index = `pmem_address[5+IDX_BITS-1:5]`, and `pmem_wdata`.
  - Load the counter with LATENCY-1.
  - Go to RESP if LATENCY==1, otherwise go to BUSY.
- BUSY:
  - Decrement the counter.
  - At counter==1, go to RESP on the next edge.
  - If the captured op's request line is low, abort: go to IDLE, commit no write, produce no `pmem_resp`.
- RESP:
  - Assert `pmem_resp`.
  - Write: store the captured data into array[index] at the end of this cycle.
  - Read: `pmem_rdata` presents array[index] as read from a registered array output.
  - Always go to IDLE.
  - Request levels seen during RESP are never treated as new requests.
- Back-to-back requests: a request already high in the first IDLE cycle after RESP is accepted in that cycle. This covers the cache's write-back followed by a refill.
- Address aliasing: bits above the index field are ignored. Addresses that differ only there map to the same line.
- `pmem_rdata` holds its last read value until the next read completes. Writes do not change it.
- Array contents are not cleared by reset. Reads of never-written lines return X in simulation.
- Op switching mid-BUSY (for example, read drops and write rises) is treated as an abort of the captured op. The new op is accepted from IDLE.

## Timing
- Reset values: state IDLE, counter 0, `pmem_resp` 0, `pmem_rdata` 0.
- Reset asserted mid-request: the next edge returns the block to IDLE. No pending write commits and no `pmem_resp` is produced.
- Latency: a request first seen high in cycle 0 (IDLE) gets `pmem_resp` in cycle LATENCY, pulse width exactly 1.
- Throughput: one request per LATENCY+1 cycles (accept, BUSY × (LATENCY-1), RESP).
- Write visibility: a read accepted after a write's RESP cycle returns the written data.
- No combinational path from request inputs to `pmem_resp` or `pmem_rdata`. Both outputs are driven from registers or state decode only.
- Counter width: ceil(log2(LATENCY+1)). No wrap, because the counter is never decremented below 1 in BUSY.

## Test plan
- Reset, LATENCY=4: hold `rst_n`=0 for 2 cycles → `pmem_resp`=0, `pmem_rdata`=0, block in IDLE; raise `pmem_read` in cycle 0 → `pmem_resp`=1 only in cycle 4.
- Write then read:
  - Write 0xA5…A5 (256-bit) to address 0x0000_0040, then read 0x0000_0040 → `pmem_rdata`=0xA5…A5 in the read's RESP cycle.
  - Read 0x0000_0060 (after writing 0x5A…5A there) → 0x5A…5A.
- Back-to-back:
  - `pmem_write` held through RESP, dropped, and `pmem_read` raised the next cycle → two distinct `pmem_resp` pulses, 5 cycles apart (LATENCY=4).
  - `pmem_read` held high through RESP → no spurious second pulse in the RESP cycle itself.
- Abort:
  - Write to 0x80 dropped in BUSY cycle 2 → no `pmem_resp`, and a later read of 0x80 returns the prior contents.
  - `rst_n`=0 during BUSY → same behaviour.
- Aliasing and priority (IDX_BITS=8):
  - Write 0x1234 pattern to 0x0000_2020; read 0xFFFF_2020 → same pattern.
  - Assert read and write together → treated as a write.
- LATENCY=1 build: request in cycle 0 → `pmem_resp` in cycle 1; continuous alternating requests → one pulse every 2 cycles.
